// File: rtl/nco_pkg.sv
// Shared defaults and scheduler state encoding for the multi-channel NCO front end.
package nco_pkg;
   localparam int NCH      = 4;
   localparam int PHASE_W  = 32;
   localparam int PH_OUT_W = 16;
   localparam int DATA_W   = 16;
   localparam int CORE_LAT = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/nco_tag_pipe.sv
// Delay line carrying {valid, channel} of each core issue so results can be
// steered back to their channel when the core answers.
module nco_tag_pipe #(
   parameter int DEPTH = 4,
   parameter int CH_W  = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            i_vld,
   input  logic [CH_W-1:0] i_ch,
   output logic            o_vld,
   output logic [CH_W-1:0] o_ch,
   output logic            o_busy
);
   logic [DEPTH:1]           vld_pipe;
   logic [DEPTH:1][CH_W-1:0] ch_pipe;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe <= '0;
         ch_pipe  <= '0;
      end else begin
         vld_pipe[1] <= i_vld;
         ch_pipe[1]  <= i_ch;
         for (int s = 2; s <= DEPTH; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            ch_pipe[s]  <= ch_pipe[s-1];
         end
      end
   end

   assign o_vld  = vld_pipe[DEPTH];
   assign o_ch   = ch_pipe[DEPTH];
   assign o_busy = |vld_pipe;
endmodule

// File: rtl/nco_sched.sv
// Time-multiplexes NCH phase accumulators onto one shared sin/cos core and
// demultiplexes the core results back into per-channel held samples.
module nco_sched #(
   parameter int NCH      = nco_pkg::NCH,
   parameter int PHASE_W  = nco_pkg::PHASE_W,
   parameter int PH_OUT_W = nco_pkg::PH_OUT_W,
   parameter int DATA_W   = nco_pkg::DATA_W,
   parameter int CORE_LAT = nco_pkg::CORE_LAT
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic                       cfg_we_i,
   input  logic                       cfg_clr_i,
   input  logic [$clog2(NCH)-1:0]     cfg_ch_i,
   input  logic [PHASE_W-1:0]         cfg_fcw_i,
   output logic                       phase_valid_o,
   output logic [PH_OUT_W-1:0]        phase_o,
   output logic [$clog2(NCH)-1:0]     phase_ch_o,
   input  logic                       core_valid_i,
   input  logic [DATA_W-1:0]          core_sin_i,
   input  logic [DATA_W-1:0]          core_cos_i,
   output logic [NCH-1:0]             valid_o,
   output logic [NCH-1:0][DATA_W-1:0] sin_o,
   output logic [NCH-1:0][DATA_W-1:0] cos_o,
   output logic                       err_o
);
   import nco_pkg::*;

   localparam int CH_W = $clog2(NCH);

   state_t                     r_state, w_next;
   logic [CH_W-1:0]            r_cnt;
   logic [NCH-1:0][PHASE_W-1:0] r_acc, r_fcw;
   logic                       r_pvld;
   logic [PH_OUT_W-1:0]        r_ph;
   logic [CH_W-1:0]            r_pch;
   logic [NCH-1:0]             r_vld;
   logic [NCH-1:0][DATA_W-1:0] r_sin, r_cos;
   logic                       r_err;
   logic                       w_issue, w_pipe_busy, w_tag_vld;
   logic [CH_W-1:0]            w_tag_ch;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // An issue sitting in the output register still counts as in flight.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (en_i) w_next = S_RUN;
         S_RUN:   if (!en_i) w_next = S_DRAIN;
         S_DRAIN: begin
            if (en_i)                         w_next = S_RUN;
            else if (!(r_pvld || w_pipe_busy)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_issue = (r_state == S_RUN);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt  <= '0;
         r_pvld <= 1'b0;
         r_ph   <= '0;
         r_pch  <= '0;
      end else begin
         r_pvld <= w_issue;
         if (w_issue) begin
            r_ph  <= r_acc[r_cnt][PHASE_W-1 -: PH_OUT_W];
            r_pch <= r_cnt;
            r_cnt <= (r_cnt == CH_W'(NCH-1)) ? '0 : r_cnt + 1'b1;
         end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
         end
      end
   end

   // Clear beats the accumulate; the accumulate always sees the pre-write FCW.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc <= '0;
         r_fcw <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cfg_clr_i && cfg_ch_i == CH_W'(i))
               r_acc[i] <= '0;
            else if (w_issue && r_cnt == CH_W'(i))
               r_acc[i] <= r_acc[i] + r_fcw[i];
            if (cfg_we_i && cfg_ch_i == CH_W'(i))
               r_fcw[i] <= cfg_fcw_i;
         end
      end
   end

   nco_tag_pipe #(.DEPTH(CORE_LAT), .CH_W(CH_W)) u_tag (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_vld  (r_pvld),
      .i_ch   (r_pch),
      .o_vld  (w_tag_vld),
      .o_ch   (w_tag_ch),
      .o_busy (w_pipe_busy)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vld <= '0;
         r_sin <= '0;
         r_cos <= '0;
         r_err <= 1'b0;
      end else begin
         r_vld <= '0;
         if (w_tag_vld) begin
            r_vld[w_tag_ch] <= 1'b1;
            r_sin[w_tag_ch] <= core_sin_i;
            r_cos[w_tag_ch] <= core_cos_i;
         end
         if (core_valid_i != w_tag_vld) r_err <= 1'b1;
      end
   end

   assign phase_valid_o = r_pvld;
   assign phase_o       = r_ph;
   assign phase_ch_o    = r_pch;
   assign valid_o       = r_vld;
   assign sin_o         = r_sin;
   assign cos_o         = r_cos;
   assign err_o         = r_err;
endmodule

// File: tb/tb_nco_sched.sv
// Bench for nco_sched: transaction-level channel/accumulator model plus an
// echoing core model, directed scenarios followed by random configuration traffic.
module tb_nco_sched;
   localparam int NCH = 4, LAT = 4, HN = 4096;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   logic clk_i = 1'b0, rst_ni = 1'b1, en_i = 1'b0;
   logic cfg_we_i = 1'b0, cfg_clr_i = 1'b0, core_valid_i = 1'b0;
   logic [1:0] cfg_ch_i = '0;
   logic [31:0] cfg_fcw_i = '0;
   logic [15:0] core_sin_i = '0, core_cos_i = '0;
   logic phase_valid_o, err_o;
   logic [15:0] phase_o;
   logic [1:0] phase_ch_o;
   logic [NCH-1:0] valid_o;
   logic [NCH-1:0][15:0] sin_o, cos_o;

   always #5 clk_i = ~clk_i;

   nco_sched dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
      .cfg_we_i(cfg_we_i), .cfg_clr_i(cfg_clr_i), .cfg_ch_i(cfg_ch_i), .cfg_fcw_i(cfg_fcw_i),
      .phase_valid_o(phase_valid_o), .phase_o(phase_o), .phase_ch_o(phase_ch_o),
      .core_valid_i(core_valid_i), .core_sin_i(core_sin_i), .core_cos_i(core_cos_i),
      .valid_o(valid_o), .sin_o(sin_o), .cos_o(cos_o), .err_o(err_o)
   );

   int nvec = 0, nerr = 0, cyc = 0, hbase = 0;
   bit drop = 1'b0;

   // reference model state
   logic [31:0] m_acc [NCH];
   logic [31:0] m_fcw [NCH];
   int m_mode, m_next;
   int fq_ch[$], fq_due[$];
   logic [15:0] fq_ph[$];
   bit e_pv, e_err;
   int e_ch;
   logic [15:0] e_ph;
   logic [NCH-1:0] e_vld;
   logic [NCH-1:0][15:0] e_sin, e_cos;

   // core model history, indexed by edge number
   bit hv [HN];
   logic [15:0] hph [HN];
   logic [1:0] hch [HN];

   function automatic logic [15:0] fsin(input logic [15:0] p, input logic [1:0] c);
      return p ^ 16'h5A5A ^ {14'd0, c};
   endfunction
   function automatic logic [15:0] fcos(input logic [15:0] p, input logic [1:0] c);
      return p + 16'h1234 + {14'd0, c};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) begin m_acc[i] = '0; m_fcw[i] = '0; end
      m_mode = M_IDLE; m_next = 0;
      fq_ch.delete(); fq_due.delete(); fq_ph.delete();
      e_pv = 0; e_err = 0; e_ch = 0; e_ph = '0; e_vld = '0; e_sin = '0; e_cos = '0;
   endtask

   task automatic step();
      int k, c;
      bit infl, tagv;
      logic [15:0] ph;
      k = cyc - LAT;
      if (k >= hbase && k >= 0) begin
         core_valid_i = hv[k % HN] & ~drop;
         core_sin_i   = fsin(hph[k % HN], hch[k % HN]);
         core_cos_i   = fcos(hph[k % HN], hch[k % HN]);
      end else core_valid_i = 1'b0;
      cyc++;
      infl = (fq_due.size() != 0);
      tagv = 0;
      e_vld = '0;
      if (fq_due.size() != 0 && fq_due[0] == cyc) begin
         c = fq_ch.pop_front(); ph = fq_ph.pop_front(); void'(fq_due.pop_front());
         tagv = 1; e_vld[c] = 1'b1;
         e_sin[c] = fsin(ph, 2'(c)); e_cos[c] = fcos(ph, 2'(c));
      end
      if (core_valid_i !== tagv) e_err = 1;
      e_pv = (m_mode == M_RUN);
      if (e_pv) begin
         e_ch = m_next; e_ph = m_acc[m_next][31:16];
         m_acc[m_next] = m_acc[m_next] + m_fcw[m_next];
         fq_ch.push_back(m_next); fq_ph.push_back(e_ph); fq_due.push_back(cyc + LAT + 1);
         m_next = (m_next + 1) % NCH;
      end
      if (cfg_clr_i) m_acc[cfg_ch_i] = '0;
      if (cfg_we_i)  m_fcw[cfg_ch_i] = cfg_fcw_i;
      case (m_mode)
         M_IDLE:  if (en_i) begin m_mode = M_RUN; m_next = 0; end
         M_RUN:   if (!en_i) m_mode = M_DRAIN;
         default: if (en_i) m_mode = M_RUN; else if (!infl) m_mode = M_IDLE;
      endcase
      @(posedge clk_i); #1;
      hv[cyc % HN] = phase_valid_o; hph[cyc % HN] = phase_o; hch[cyc % HN] = phase_ch_o;
      chk("phase_valid", 64'(phase_valid_o), 64'(e_pv));
      if (e_pv) begin
         chk("phase", 64'(phase_o), 64'(e_ph));
         chk("phase_ch", 64'(phase_ch_o), 64'(e_ch));
      end
      chk("valid_o", 64'(valid_o), 64'(e_vld));
      chk("sin_o", sin_o, e_sin);
      chk("cos_o", cos_o, e_cos);
      chk("err_o", 64'(err_o), 64'(e_err));
   endtask

   task automatic do_reset();
      #2;
      rst_ni = 1'b0; en_i = 0; cfg_we_i = 0; cfg_clr_i = 0; core_valid_i = 0;
      #1;
      chk("rst_phase_valid", 64'(phase_valid_o), 64'd0);
      chk("rst_phase", 64'(phase_o), 64'd0);
      chk("rst_phase_ch", 64'(phase_ch_o), 64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_sin", sin_o, 64'd0);
      chk("rst_cos", cos_o, 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      model_clear();
      @(posedge clk_i); #1;
      cyc++;
      hv[cyc % HN] = 0;
      hbase = cyc + 1;
      rst_ni = 1'b1;
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [31:0] fcw);
      cfg_we_i = 1; cfg_ch_i = ch; cfg_fcw_i = fcw;
      step();
      cfg_we_i = 0;
   endtask

   initial begin
      logic [15:0] q0[$], q1[$], q2[$];
      logic [NCH-1:0] qv[$];
      int first_iss, first_vo;
      first_iss = -1; first_vo = -1;

      do_reset();
      repeat (4) step();                           // idle: no issues

      cfg(2'd0, 32'h0001_0000);
      cfg(2'd1, 32'h8000_0000);
      cfg(2'd2, 32'h0100_0000);
      cfg(2'd3, $urandom);

      en_i = 1;
      repeat (14) begin
         step();
         if (phase_valid_o && first_iss < 0) first_iss = cyc;
         if (valid_o != 0) begin
            if (first_vo < 0) first_vo = cyc;
            qv.push_back(valid_o);
         end
         if (phase_valid_o && phase_ch_o == 2'd0) q0.push_back(phase_o);
         if (phase_valid_o && phase_ch_o == 2'd1) q1.push_back(phase_o);
      end
      chk("issue_to_valid_latency", 64'(first_vo - first_iss), 64'(LAT + 1));
      chk("ch0_count", 64'(q0.size() >= 3), 64'd1);
      if (q0.size() >= 3) begin
         chk("ch0_ph0", 64'(q0[0]), 64'h0000);
         chk("ch0_ph1", 64'(q0[1]), 64'h0001);
         chk("ch0_ph2", 64'(q0[2]), 64'h0002);
      end
      chk("ch1_count", 64'(q1.size() >= 3), 64'd1);
      if (q1.size() >= 3) begin
         chk("ch1_ph0", 64'(q1[0]), 64'h0000);
         chk("ch1_ph1", 64'(q1[1]), 64'h8000);
         chk("ch1_ph2", 64'(q1[2]), 64'h0000);
      end
      chk("valid_count", 64'(qv.size() >= 4), 64'd1);
      if (qv.size() >= 4) begin
         chk("valid_seq0", 64'(qv[0]), 64'h1);
         chk("valid_seq1", 64'(qv[1]), 64'h2);
         chk("valid_seq2", 64'(qv[2]), 64'h4);
         chk("valid_seq3", 64'(qv[3]), 64'h8);
      end

      // write + clear ch2 in the very cycle it issues
      for (int i = 0; i < 8 && m_next != 2; i++) step();
      cfg_we_i = 1; cfg_clr_i = 1; cfg_ch_i = 2'd2; cfg_fcw_i = 32'h0300_0000;
      step();
      if (phase_valid_o && phase_ch_o == 2'd2) q2.push_back(phase_o);
      cfg_we_i = 0; cfg_clr_i = 0;
      repeat (9) begin
         step();
         if (phase_valid_o && phase_ch_o == 2'd2) q2.push_back(phase_o);
      end
      chk("ch2_count", 64'(q2.size() >= 3), 64'd1);
      if (q2.size() >= 3) begin
         chk("ch2_after_clear", 64'(q2[1]), 64'h0000);
         chk("ch2_new_fcw", 64'(q2[2]), 64'h0300);
      end

      // stop, drain to idle
      en_i = 0;
      repeat (12) step();

      // random traffic with sticky-ish enable
      en_i = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) en_i = ~en_i;
         cfg_we_i  = ($urandom_range(0, 5) == 0);
         cfg_clr_i = ($urandom_range(0, 7) == 0);
         cfg_ch_i  = 2'($urandom_range(0, 3));
         cfg_fcw_i = $urandom;
         step();
      end
      cfg_we_i = 0; cfg_clr_i = 0;

      // suppress one core strobe while a tag is due: sticky error
      en_i = 1;
      repeat (8) step();
      drop = 1; step(); drop = 0;
      chk("err_set", 64'(err_o), 64'd1);
      repeat (5) step();

      // reset mid-run discards in-flight work
      do_reset();
      repeat (10) step();
      en_i = 1;
      repeat (10) step();
      en_i = 0;
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
